// File: rtl/dram_word_adapter_if.sv
// CPU-side word request/response bundle for dram_word_adapter.
// Latency: none; this is a plain signal bundle.
// Backpressure: the request is taken on valid & ready; the response has no ready and is a one-cycle pulse.
// Ports: cpu_req_{valid,ready,we,addr,wdata,be} carry the request;
//        cpu_rsp_{valid,rdata} carry the response.
//        master = CPU side, slave = adapter side.
interface dram_word_adapter_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_be;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;

    modport master (
        output cpu_req_valid,
        output cpu_req_we,
        output cpu_req_addr,
        output cpu_req_wdata,
        output cpu_req_be,
        input  cpu_req_ready,
        input  cpu_rsp_valid,
        input  cpu_rsp_rdata
    );

    modport slave (
        input  cpu_req_valid,
        input  cpu_req_we,
        input  cpu_req_addr,
        input  cpu_req_wdata,
        input  cpu_req_be,
        output cpu_req_ready,
        output cpu_rsp_valid,
        output cpu_rsp_rdata
    );
endinterface

// File: rtl/dram_word_adapter.sv
// 32-bit CPU word loads and stores to 128-bit single-beat DRAM line commands, with a one-line read buffer.
// Latency: a load hit responds 2 cycles after accept; a store responds 2 cycles after its wr_en cycle; a load miss responds 2 cycles after the rdata_valid cycle.
// Backpressure: one request is outstanding at a time, and cpu_req_ready is high only in IDLE; an issue waits for dram_ready.
// Ports: ui_clk/ui_rst are the clock and synchronous active-high reset; cpu is the word request/response bundle;
//        dram_* connect to the controller user interface (rd_en/wr_en/addr/wdata/mask out; calib_done/ready/rdata/rdata_valid in).
module dram_word_adapter #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    dram_word_adapter_if.slave        cpu,
    input  logic                      dram_calib_done,
    input  logic                      dram_ready,
    output logic                      dram_rd_en,
    output logic                      dram_wr_en,
    output logic [APP_ADDR_WIDTH-1:0] dram_addr,
    output logic [APP_DATA_WIDTH-1:0] dram_wdata,
    output logic [APP_MASK_WIDTH-1:0] dram_mask,
    input  logic [APP_DATA_WIDTH-1:0] dram_rdata,
    input  logic                      dram_rdata_valid
);

    // Line tag is byte address [APP_ADDR_WIDTH:4]. The controller addresses 2-byte units, so a line is {tag, 3'b000}.
    localparam int TAG_W = APP_ADDR_WIDTH - 3;

    localparam logic [2:0] S_CALIB   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]                state;
    logic [2:0]                next_state;
    logic                      calib_q;

    logic                      req_we;
    logic [TAG_W-1:0]          req_tag;
    logic [1:0]                req_lane;
    logic [31:0]               req_wdata;
    logic [3:0]                req_be;

    logic                      buf_valid;
    logic [TAG_W-1:0]          buf_tag;
    logic [APP_DATA_WIDTH-1:0] buf_data;
    logic [31:0]               resp_data;

    logic [TAG_W-1:0]          in_tag;
    logic [1:0]                in_lane;
    logic                      accept;
    logic                      in_hit;
    logic                      req_hit;
    logic [APP_DATA_WIDTH-1:0] line_wdata;
    logic [APP_DATA_WIDTH-1:0] patched;
    logic [APP_MASK_WIDTH-1:0] line_mask;
    logic                      unused_addr_bits;

    assign in_tag     = cpu.cpu_req_addr[APP_ADDR_WIDTH:4];
    assign in_lane    = cpu.cpu_req_addr[3:2];
    assign accept     = cpu.cpu_req_valid && cpu.cpu_req_ready;
    assign in_hit     = buf_valid && (buf_tag == in_tag);
    assign req_hit    = buf_valid && (buf_tag == req_tag);
    assign line_wdata = {4{req_wdata}};

    // Word-offset bits and bits above the controller's reach are not part of the line address.
    assign unused_addr_bits = ^{cpu.cpu_req_addr[31:APP_ADDR_WIDTH+1], cpu.cpu_req_addr[1:0]};

    // The mask is inverted (1 = keep). Only the addressed lane follows the byte enables.
    // patched is the buffer line with the pending store merged into it, used on a store hit.
    always_comb begin
        line_mask = '1;
        line_mask[4*req_lane +: 4] = ~req_be;
        patched = buf_data;
        for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
                patched[32*req_lane + 8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CALIB:   if (calib_q) next_state = S_IDLE;
            S_IDLE:    if (accept) next_state = (!cpu.cpu_req_we && in_hit) ? S_RESP : S_ISSUE;
            S_ISSUE:   if (dram_ready) next_state = S_HOLD;
            // The controller's ready lags by one cycle, so this cycle ignores it.
            S_HOLD:    next_state = req_we ? S_RESP : S_RD_WAIT;
            S_RD_WAIT: if (dram_rdata_valid) next_state = S_RESP;
            S_RESP:    next_state = S_IDLE;
            default:   next_state = S_CALIB;
        endcase
    end

    // All outputs are registered. ready is derived from next_state so it lines up with IDLE.
    // calib_done passes through calib_q, so ready rises two cycles after calib_done.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state             <= S_CALIB;
            calib_q           <= 1'b0;
            req_we            <= 1'b0;
            req_tag           <= '0;
            req_lane          <= '0;
            req_wdata         <= '0;
            req_be            <= '0;
            buf_valid         <= 1'b0;
            buf_tag           <= '0;
            buf_data          <= '0;
            resp_data         <= '0;
            cpu.cpu_req_ready <= 1'b0;
            cpu.cpu_rsp_valid <= 1'b0;
            cpu.cpu_rsp_rdata <= '0;
            dram_rd_en        <= 1'b0;
            dram_wr_en        <= 1'b0;
            dram_addr         <= '0;
            dram_wdata        <= '0;
            dram_mask         <= '0;
        end else begin
            state             <= next_state;
            calib_q           <= dram_calib_done;
            cpu.cpu_req_ready <= (next_state == S_IDLE);
            cpu.cpu_rsp_valid <= (state == S_RESP);
            cpu.cpu_rsp_rdata <= (state == S_RESP) ? resp_data : 32'd0;
            dram_rd_en        <= 1'b0;
            dram_wr_en        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_we    <= cpu.cpu_req_we;
                        req_tag   <= in_tag;
                        req_lane  <= in_lane;
                        req_wdata <= cpu.cpu_req_wdata;
                        req_be    <= cpu.cpu_req_be;
                        // A load hit is answered straight from the buffer; stores always answer 0.
                        resp_data <= (!cpu.cpu_req_we && in_hit) ? buf_data[32*in_lane +: 32] : 32'd0;
                    end
                end
                S_ISSUE: begin
                    if (dram_ready) begin
                        dram_rd_en <= !req_we;
                        dram_wr_en <= req_we;
                        dram_addr  <= {req_tag, 3'b000};
                        dram_wdata <= line_wdata;
                        dram_mask  <= line_mask;
                        // Write-through: patch the buffer on a hit; a miss does not allocate.
                        if (req_we && req_hit) begin
                            buf_data <= patched;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (dram_rdata_valid) begin
                        buf_valid <= 1'b1;
                        buf_tag   <= req_tag;
                        buf_data  <= dram_rdata;
                        resp_data <= dram_rdata[32*req_lane +: 32];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_adapter.sv
module tb_dram_word_adapter;

    logic         ui_clk = 1'b0;
    logic         ui_rst;
    logic         dram_calib_done;
    logic         dram_ready;
    logic         dram_rd_en;
    logic         dram_wr_en;
    logic [27:0]  dram_addr;
    logic [127:0] dram_wdata;
    logic [15:0]  dram_mask;
    logic [127:0] dram_rdata;
    logic         dram_rdata_valid;

    always #5 ui_clk = ~ui_clk;

    dram_word_adapter_if bus ();

    dram_word_adapter dut (
        .ui_clk           (ui_clk),
        .ui_rst           (ui_rst),
        .cpu              (bus),
        .dram_calib_done  (dram_calib_done),
        .dram_ready       (dram_ready),
        .dram_rd_en       (dram_rd_en),
        .dram_wr_en       (dram_wr_en),
        .dram_addr        (dram_addr),
        .dram_wdata       (dram_wdata),
        .dram_mask        (dram_mask),
        .dram_rdata       (dram_rdata),
        .dram_rdata_valid (dram_rdata_valid)
    );

    localparam logic [127:0] LINE1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE2 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

    int   vectors     = 0;
    int   miscompares = 0;
    int   rd_cnt      = 0;
    int   wr_cnt      = 0;
    int   rsp_cnt     = 0;
    int   proto_viol  = 0;
    logic prev_en     = 1'b0;

    // Command/response activity counters and the command-spacing rule.
    always @(posedge ui_clk) begin
        if (dram_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
        if (dram_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
        if (bus.cpu_rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
        if ((dram_rd_en === 1'b1 && dram_wr_en === 1'b1) ||
            ((dram_rd_en === 1'b1 || dram_wr_en === 1'b1) && prev_en === 1'b1))
            proto_viol <= proto_viol + 1;
        prev_en <= (dram_rd_en === 1'b1) || (dram_wr_en === 1'b1);
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request until it is accepted (bounded); returns just after the accept edge.
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic ok);
        ok = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wd;
        bus.cpu_req_be    = be;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.cpu_req_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.cpu_req_valid = 1'b0;
    endtask

    task automatic wait_en(output int lat);
        lat = -1;
        for (int i = 1; i <= 50 && lat < 0; i++) begin
            tick();
            if (dram_rd_en === 1'b1 || dram_wr_en === 1'b1) lat = i;
        end
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] data);
        lat  = -1;
        data = '0;
        for (int i = 1; i <= 50 && lat < 0; i++) begin
            tick();
            if (bus.cpu_rsp_valid === 1'b1) begin
                lat  = i;
                data = bus.cpu_rsp_rdata;
            end
        end
    endtask

    // Called in the rd_en cycle: steps into RD_WAIT, then returns the line for one cycle.
    task automatic deliver(input logic [127:0] line);
        tick();
        dram_rdata       = line;
        dram_rdata_valid = 1'b1;
        tick();
        dram_rdata_valid = 1'b0;
    endtask

    initial begin
        logic        ok;
        logic        seen;
        int          lat;
        int          base;
        logic [31:0] data;

        ui_rst            = 1'b1;
        dram_calib_done   = 1'b0;
        dram_ready        = 1'b1;
        dram_rdata        = '0;
        dram_rdata_valid  = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdata = '0;
        bus.cpu_req_be    = '0;
        repeat (3) tick();

        chk("rst_ready", 128'(bus.cpu_req_ready), 128'd0);
        chk("rst_en", 128'({dram_rd_en, dram_wr_en}), 128'd0);
        chk("rst_rsp", 128'(bus.cpu_rsp_valid), 128'd0);
        chk("rst_addr_mask", 128'({dram_addr, dram_mask}), 128'd0);

        // Calibration: request pending, nothing may happen.
        ui_rst            = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h0000_0124;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.cpu_req_ready !== 1'b0 || dram_rd_en !== 1'b0 || dram_wr_en !== 1'b0) seen = 1'b1;
        end
        chk("calib_quiet", 128'(seen), 128'd0);
        dram_calib_done = 1'b1;
        tick();
        chk("calib_plus1_ready", 128'(bus.cpu_req_ready), 128'd0);
        tick();
        chk("calib_plus2_ready", 128'(bus.cpu_req_ready), 128'd1);
        bus.cpu_req_valid = 1'b0;

        // Load miss to 0x124 (tag 0x12, lane 1).
        base = rd_cnt;
        req(1'b0, 32'h0000_0124, 32'h0, 4'h0, ok);
        chk("miss_accept", 128'(ok), 128'd1);
        wait_en(lat);
        chk("miss_en_lat", 128'(lat), 128'd1);
        chk("miss_en_kind", 128'({dram_rd_en, dram_wr_en}), 128'b10);
        chk("miss_addr", 128'(dram_addr), 128'h90);
        deliver(LINE1);
        wait_rsp(lat, data);
        chk("miss_rsp_lat", 128'(lat), 128'd1);
        chk("miss_rdata", 128'(data), 128'h22222222);
        chk("miss_rd_count", 128'(rd_cnt - base), 128'd1);

        // Load hit to 0x128 (lane 2).
        base = rd_cnt;
        req(1'b0, 32'h0000_0128, 32'h0, 4'h0, ok);
        wait_rsp(lat, data);
        chk("hit_rsp_lat", 128'(lat), 128'd1);
        chk("hit_rdata", 128'(data), 128'h33333333);
        chk("hit_no_rd", 128'(rd_cnt - base), 128'd0);

        // Full-word store hit to 0x120 (lane 0).
        req(1'b1, 32'h0000_0120, 32'hDEADBEEF, 4'hF, ok);
        wait_en(lat);
        chk("st_en_lat", 128'(lat), 128'd1);
        chk("st_en_kind", 128'({dram_rd_en, dram_wr_en}), 128'b01);
        chk("st_addr", 128'(dram_addr), 128'h90);
        chk("st_mask", 128'(dram_mask), 128'hFFF0);
        chk("st_wdata", dram_wdata, {4{32'hDEADBEEF}});
        wait_rsp(lat, data);
        chk("st_rsp_lat", 128'(lat), 128'd2);
        chk("st_rdata_zero", 128'(data), 128'd0);

        base = rd_cnt;
        req(1'b0, 32'h0000_0120, 32'h0, 4'h0, ok);
        wait_rsp(lat, data);
        chk("patch_full_rdata", 128'(data), 128'hDEADBEEF);
        chk("patch_full_no_rd", 128'(rd_cnt - base), 128'd0);

        // Partial store hit to 0x124: low two bytes of lane 1 only.
        req(1'b1, 32'h0000_0124, 32'h55667788, 4'b0011, ok);
        wait_en(lat);
        chk("pst_mask", 128'(dram_mask), 128'hFFCF);
        wait_rsp(lat, data);
        req(1'b0, 32'h0000_0124, 32'h0, 4'h0, ok);
        wait_rsp(lat, data);
        chk("patch_part_rdata", 128'(data), 128'h22227788);

        // Store miss to 0x134 (lane 1, tag 0x13) under dram_ready backpressure.
        dram_ready = 1'b0;
        base = wr_cnt;
        req(1'b1, 32'h0000_0134, 32'hAABBCCDD, 4'b0101, ok);
        repeat (10) tick();
        chk("bp_no_wr", 128'(wr_cnt - base), 128'd0);
        dram_ready = 1'b1;
        wait_en(lat);
        chk("bp_en_lat", 128'(lat), 128'd1);
        chk("bp_addr", 128'(dram_addr), 128'h98);
        chk("bp_mask", 128'(dram_mask), 128'hFFAF);
        chk("bp_wdata", dram_wdata, {4{32'hAABBCCDD}});
        wait_rsp(lat, data);
        chk("bp_rsp_lat", 128'(lat), 128'd2);
        chk("bp_one_wr", 128'(wr_cnt - base), 128'd1);

        // A store miss must leave the buffered line in place.
        base = rd_cnt;
        req(1'b0, 32'h0000_012C, 32'h0, 4'h0, ok);
        wait_rsp(lat, data);
        chk("nowa_rdata", 128'(data), 128'h44444444);
        chk("nowa_no_rd", 128'(rd_cnt - base), 128'd0);

        // Reset while waiting for read data, then a stray rdata_valid.
        req(1'b0, 32'h0000_0200, 32'h0, 4'h0, ok);
        wait_en(lat);
        chk("rr_addr", 128'(dram_addr), 128'h100);
        tick();
        ui_rst = 1'b1;
        tick();
        ui_rst = 1'b0;
        chk("rr_outputs", 128'({bus.cpu_req_ready, dram_rd_en, dram_wr_en, bus.cpu_rsp_valid}), 128'd0);
        base = rsp_cnt;
        dram_rdata       = LINE1;
        dram_rdata_valid = 1'b1;
        tick();
        dram_rdata_valid = 1'b0;
        repeat (5) tick();
        chk("rr_no_rsp", 128'(rsp_cnt - base), 128'd0);

        base = rd_cnt;
        req(1'b0, 32'h0000_0124, 32'h0, 4'h0, ok);
        chk("rr_accept", 128'(ok), 128'd1);
        wait_en(lat);
        chk("rr_miss_lat", 128'(lat), 128'd1);
        chk("rr_miss_addr", 128'(dram_addr), 128'h90);
        deliver(LINE2);
        wait_rsp(lat, data);
        chk("rr_rdata", 128'(data), 128'hCCCCCCCC);
        chk("rr_rd_count", 128'(rd_cnt - base), 128'd1);

        repeat (3) tick();
        chk("en_spacing", 128'(proto_viol), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
